uart_mem_loader: RTL and testbench

Serial program loader in the tiny-CPU design. It receives a framed image over a UART RX pin (8N1) and writes it word-by-word into `memory` using the same toggle handshake (`run`/`done`, `mem_cmd_write`) the CPU uses. It holds the CPU off during a transfer. It sits upstream of `memory`, muxed with the CPU's port by `cpu_hold`.

---
 rtl/uart_mem_loader.sv | 160 ++++++++++++++++
 tb/tb_uart_mem_loader.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_mem_loader.sv
// Serial program loader: receives an 8N1 UART frame and writes it into memory
// through the run/done toggle handshake, holding the CPU off while it works.
module uart_mem_loader #(
  parameter int CLKS_PER_BIT = 234,
  parameter int TIMEOUT_CLKS = 65535
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  output logic [15:0] mem_addr,
  output logic [1:0]  mem_cmd,
  output logic        mem_run,
  output logic [15:0] mem_wr_data,
  input  logic        mem_done,
  output logic        cpu_hold,
  output logic [15:0] loaded_words,
  output logic [3:0]  err
);
  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int TW   = $clog2(TIMEOUT_CLKS + 1);
  localparam int HALF = CLKS_PER_BIT / 2;
  localparam logic [1:0] CMD_NOP = 2'b00;
  localparam logic [1:0] CMD_WR  = 2'b10;

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_st_t;
  typedef enum logic [2:0] {SYNC, ADDR_H, ADDR_L, CNT_H, CNT_L, DATA_H, DATA_L, CSUM} ps_t;

  rx_st_t        rst;
  logic          rx_s1, rx_s2, rx_prev;
  logic [CW-1:0] clk_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg, rx_byte;
  logic          byte_valid, frame_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_s1      <= 1'b1;
      rx_s2      <= 1'b1;
      rx_prev    <= 1'b1;
      rst        <= R_IDLE;
      clk_cnt    <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      rx_byte    <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_s1      <= rx;
      rx_s2      <= rx_s1;
      rx_prev    <= rx_s2;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (rst)
        R_IDLE: if (rx_prev && !rx_s2) begin
          rst     <= R_START;
          clk_cnt <= '0;
        end
        // Mid-start re-check rejects glitches shorter than half a bit
        R_START: if (clk_cnt == CW'(HALF - 1)) begin
          clk_cnt <= '0;
          bit_idx <= '0;
          rst     <= rx_s2 ? R_IDLE : R_DATA;
        end else clk_cnt <= clk_cnt + 1'b1;
        R_DATA: if (clk_cnt == CW'(CLKS_PER_BIT - 1)) begin
          clk_cnt <= '0;
          shreg   <= {rx_s2, shreg[7:1]};
          bit_idx <= bit_idx + 1'b1;
          if (bit_idx == 3'd7) rst <= R_STOP;
        end else clk_cnt <= clk_cnt + 1'b1;
        R_STOP: if (clk_cnt == CW'(CLKS_PER_BIT - 1)) begin
          clk_cnt <= '0;
          rst     <= R_IDLE;
          if (rx_s2) begin
            byte_valid <= 1'b1;
            rx_byte    <= shreg;
          end else frame_err <= 1'b1;
        end else clk_cnt <= clk_cnt + 1'b1;
        default: rst <= R_IDLE;
      endcase
    end
  end

  ps_t           ps;
  logic [15:0]   addr, cnt;
  logic [7:0]    hi, csum;
  logic [TW-1:0] timer;
  logic          wr_busy;

  assign cpu_hold = (ps != SYNC) || wr_busy;

  always_ff @(posedge clk) begin
    if (reset) begin
      ps           <= SYNC;
      addr         <= '0;
      cnt          <= '0;
      hi           <= '0;
      csum         <= '0;
      timer        <= '0;
      wr_busy      <= 1'b0;
      mem_addr     <= '0;
      mem_cmd      <= CMD_NOP;
      mem_run      <= 1'b0;
      mem_wr_data  <= '0;
      loaded_words <= '0;
      err          <= '0;
    end else begin
      // Completion is handled first so a same-cycle new word can re-issue
      if (wr_busy && (mem_run == mem_done)) begin
        wr_busy      <= 1'b0;
        mem_cmd      <= CMD_NOP;
        loaded_words <= loaded_words + 1'b1;
      end
      if (ps == SYNC || byte_valid) timer <= '0;
      else                          timer <= timer + 1'b1;

      if (frame_err) begin
        err[0] <= 1'b1;
        ps     <= SYNC;
      end else if (byte_valid) begin
        if (ps != SYNC && ps != CSUM) csum <= csum + rx_byte;
        case (ps)
          SYNC: if (rx_byte == 8'hA5) begin
            err          <= '0;
            loaded_words <= '0;
            csum         <= '0;
            ps           <= ADDR_H;
          end
          ADDR_H: begin addr[15:8] <= rx_byte; ps <= ADDR_L; end
          ADDR_L: begin addr[7:0]  <= rx_byte; ps <= CNT_H;  end
          CNT_H:  begin cnt[15:8]  <= rx_byte; ps <= CNT_L;  end
          CNT_L: begin
            cnt[7:0] <= rx_byte;
            ps       <= ({cnt[15:8], rx_byte} == 16'd0) ? CSUM : DATA_H;
          end
          DATA_H: begin hi <= rx_byte; ps <= DATA_L; end
          DATA_L: begin
            if (mem_run == mem_done) begin
              mem_addr    <= addr;
              mem_wr_data <= {hi, rx_byte};
              mem_cmd     <= CMD_WR;
              mem_run     <= ~mem_run;
              wr_busy     <= 1'b1;
            end else err[2] <= 1'b1;
            addr <= addr + 1'b1;
            cnt  <= cnt - 1'b1;
            ps   <= (cnt == 16'd1) ? CSUM : DATA_H;
          end
          CSUM: begin
            if (rx_byte != csum) err[1] <= 1'b1;
            ps <= SYNC;
          end
          default: ps <= SYNC;
        endcase
      end else if (ps != SYNC && timer == TW'(TIMEOUT_CLKS - 1)) begin
        err[3] <= 1'b1;
        ps     <= SYNC;
      end
    end
  end
endmodule

// File: tb/tb_uart_mem_loader.sv
// Bench for uart_mem_loader: table of frames plus hand-written corner sequences;
// a memory stub scoreboards every write against expected {addr, data}.
module tb_uart_mem_loader;
  localparam int CPB = 8;
  localparam int TO  = 400;

  logic        clk = 1'b0, reset = 1'b1, rx = 1'b1, mem_done = 1'b0, stall = 1'b0;
  logic [15:0] mem_addr, mem_wr_data, loaded_words;
  logic [1:0]  mem_cmd;
  logic        mem_run, cpu_hold;
  logic [3:0]  err;

  int n_vec = 0, n_bad = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [15:0]       addr;
    int                cnt;
    logic [3:0][15:0]  w;
    bit                force_cs;
    logic [7:0]        cs;
    logic [3:0]        exp_err;
    logic [15:0]       exp_loaded;
  } vec_t;
  vec_t vt[5];

  always #5 clk = ~clk;

  uart_mem_loader #(.CLKS_PER_BIT(CPB), .TIMEOUT_CLKS(TO)) dut (
    .clk(clk), .reset(reset), .rx(rx), .mem_addr(mem_addr), .mem_cmd(mem_cmd),
    .mem_run(mem_run), .mem_wr_data(mem_wr_data), .mem_done(mem_done),
    .cpu_hold(cpu_hold), .loaded_words(loaded_words), .err(err));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Memory stub: acknowledges one clock after a request, unless stalled
  always @(negedge clk) begin
    if (reset) mem_done = 1'b0;
    else if (mem_run !== mem_done && !stall) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_write: addr %h data %h, none expected", mem_addr, mem_wr_data);
      end else check("mem_write", {mem_addr, mem_wr_data}, exp_q.pop_front());
      check("mem_cmd", {30'd0, mem_cmd}, 32'd2);
      mem_done = mem_run;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_stop);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(CPB);
    end
    rx = !bad_stop;
    tick(CPB);
    rx = 1'b1;
    tick(CPB);
  endtask

  task automatic send_frame(input vec_t v, input int push_n);
    logic [7:0]  cs;
    logic [15:0] c;
    c  = 16'(v.cnt);
    cs = v.addr[15:8] + v.addr[7:0] + c[15:8] + c[7:0];
    send_byte(8'hA5, 1'b0);
    check("hold_after_sync", {31'd0, cpu_hold}, 32'd1);
    send_byte(v.addr[15:8], 1'b0);
    send_byte(v.addr[7:0], 1'b0);
    send_byte(c[15:8], 1'b0);
    send_byte(c[7:0], 1'b0);
    for (int i = 0; i < v.cnt; i++) begin
      if (i < push_n) exp_q.push_back({v.addr + 16'(i), v.w[i]});
      cs = cs + v.w[i][15:8] + v.w[i][7:0];
      send_byte(v.w[i][15:8], 1'b0);
      send_byte(v.w[i][7:0], 1'b0);
    end
    send_byte(v.force_cs ? v.cs : cs, 1'b0);
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 2000 && cpu_hold; i++) tick(1);
    check(name, {31'd0, cpu_hold}, 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_addr"},   {16'd0, mem_addr},     32'd0);
    check({tag, "_cmd"},    {30'd0, mem_cmd},      32'd0);
    check({tag, "_run"},    {31'd0, mem_run},      32'd0);
    check({tag, "_wdata"},  {16'd0, mem_wr_data},  32'd0);
    check({tag, "_hold"},   {31'd0, cpu_hold},     32'd0);
    check({tag, "_loaded"}, {16'd0, loaded_words}, 32'd0);
    check({tag, "_err"},    {28'd0, err},          32'd0);
  endtask

  function automatic vec_t mk(input logic [15:0] a, input int n, input logic [3:0][15:0] w,
                              input bit fc, input logic [7:0] cs, input logic [3:0] e,
                              input logic [15:0] l);
    vec_t v;
    v.addr = a; v.cnt = n; v.w = w; v.force_cs = fc; v.cs = cs; v.exp_err = e; v.exp_loaded = l;
    return v;
  endfunction

  initial begin
    vec_t v;
    vt[0] = mk(16'h0010, 2, {16'h0, 16'h0, 16'hABCD, 16'h1234}, 1'b0, 8'h00, 4'b0000, 16'd2);
    vt[1] = mk(16'h0010, 2, {16'h0, 16'h0, 16'hABCD, 16'h1234}, 1'b1, 8'h00, 4'b0010, 16'd2);
    vt[2] = mk(16'hFFFF, 2, {16'h0, 16'h0, 16'h0102, 16'hBEEF}, 1'b0, 8'h00, 4'b0000, 16'd2);
    vt[3] = mk(16'h0100, 0, {16'h0, 16'h0, 16'h0, 16'h0},       1'b0, 8'h00, 4'b0000, 16'd0);
    vt[4] = mk(16'h0200, 3, {16'h0, 16'h5A00, 16'h00A5, 16'hA5A5}, 1'b0, 8'h00, 4'b0000, 16'd3);

    tick(3);
    check_reset_vals("reset");
    reset = 1'b0;
    tick(5);

    for (int k = 0; k < 5; k++) begin
      send_frame(vt[k], vt[k].cnt);
      wait_idle("hold_release");
      check("frame_err",    {28'd0, err},          {28'd0, vt[k].exp_err});
      check("frame_loaded", {16'd0, loaded_words}, {16'd0, vt[k].exp_loaded});
      check("sb_empty",     exp_q.size(),          32'd0);
    end

    // Framing error on addr_lo, then a clean frame
    send_byte(8'hA5, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h10, 1'b1);
    tick(4);
    check("ferr_err",  {28'd0, err},      32'h1);
    check("ferr_hold", {31'd0, cpu_hold}, 32'd0);
    send_frame(vt[0], 2);
    wait_idle("ferr_recover_hold");
    check("ferr_recover_err",    {28'd0, err},          32'd0);
    check("ferr_recover_loaded", {16'd0, loaded_words}, 32'd2);

    // Stalled memory: first word held, second dropped
    stall = 1'b1;
    v = mk(16'h0020, 2, {16'h0, 16'h0, 16'h2222, 16'h1111}, 1'b0, 8'h00, 4'b0100, 16'd1);
    send_frame(v, 1);
    tick(CPB * 2);
    check("stall_hold",   {31'd0, cpu_hold},     32'd1);
    check("stall_err",    {28'd0, err},          32'h4);
    check("stall_loaded", {16'd0, loaded_words}, 32'd0);
    check("stall_cmd",    {30'd0, mem_cmd},      32'd2);
    check("stall_addr",   {16'd0, mem_addr},     32'h0020);
    check("stall_wdata",  {16'd0, mem_wr_data},  32'h1111);
    stall = 1'b0;
    wait_idle("stall_release_hold");
    check("stall_release_loaded", {16'd0, loaded_words}, 32'd1);
    check("stall_sb_empty",       exp_q.size(),          32'd0);

    // Timeout after A5 00
    send_byte(8'hA5, 1'b0);
    send_byte(8'h00, 1'b0);
    check("to_hold_before", {31'd0, cpu_hold}, 32'd1);
    tick(TO + 50);
    check("to_err",  {28'd0, err},      32'h8);
    check("to_hold", {31'd0, cpu_hold}, 32'd0);

    // Reset in the middle of DATA_H
    send_byte(8'hA5, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h30, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h01, 1'b0);
    rx = 1'b0;
    tick(CPB * 2);
    reset = 1'b1;
    rx    = 1'b1;
    tick(1);
    check_reset_vals("midreset");
    reset = 1'b0;
    tick(CPB * 12);
    check("post_reset_err",  {28'd0, err},      32'd0);
    check("post_reset_hold", {31'd0, cpu_hold}, 32'd0);
    send_frame(vt[2], 2);
    wait_idle("post_reset_frame_hold");
    check("post_reset_loaded", {16'd0, loaded_words}, 32'd2);
    check("final_sb_empty",    exp_q.size(),          32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
